// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect, Imem request/response and the dispatch-side packet.
// The packet type lives in fetch_queue_pkg so the bench and the design share it.
package fetch_queue_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } if_dp_packet_t;
endpackage

interface fetch_queue_if #(
  parameter int FQ_DEPTH = 8
);
  import fetch_queue_pkg::*;
  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_inst;
  logic          dp_ready;
  if_dp_packet_t if_packet;
  logic [CW-1:0] fq_count;
  logic          fetch_halted;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_inst, dp_ready,
    output mem_req_valid, mem_req_addr, if_packet, fq_count, fetch_halted
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_inst, dp_ready,
    input  mem_req_valid, mem_req_addr, if_packet, fq_count, fetch_halted
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC stream, in-order Imem requests, instruction FIFO, redirect flush.
// Optional WFI halt enabled by defining FETCH_HALT_STOP_EN.
module fetch_queue_chk #(
  parameter int FQ_DEPTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = 4,
  parameter int OW              = 3
) (
  input logic          clock,
  input logic          reset,
  input logic          i_push,
  input logic          i_pop,
  input logic [CW-1:0] i_count,
  input logic          i_resp,
  input logic [OW-1:0] i_outstanding
);
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(i_push && !i_pop && (i_count == CW'(FQ_DEPTH))));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
    !(i_pop && (i_count == CW'(0))));
  a_resp_expected: assert property (@(posedge clock) disable iff (!reset)
    !(i_resp && (i_outstanding == OW'(0))));
  a_outstanding_bound: assert property (@(posedge clock) disable iff (!reset)
    (32'(i_outstanding) <= 32'(MAX_OUTSTANDING)));
endmodule

module fetch_queue #(
  parameter int          FQ_DEPTH        = 8,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
`ifdef FETCH_HALT_STOP_EN
  localparam logic [31:0] WFI_INST = 32'h1050_0073;
`endif

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_q_inst [FQ_DEPTH];
  logic [31:0]   r_q_pc   [FQ_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_if_pc  [MAX_OUTSTANDING];
  logic [IW-1:0] r_if_rd;
  logic [IW-1:0] r_if_wr;
  logic [OW-1:0] r_outstanding;
  logic [OW-1:0] r_discard;
  logic          r_halted;

  logic [31:0]   w_used;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_wfi;
  logic          w_pkt_valid;
  logic [OW-1:0] w_resp_left;
  logic [OW-1:0] w_outstanding_nxt;
  logic [OW-1:0] w_discard_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_halted_nxt;

  function automatic logic [IW-1:0] next_if_ptr(input logic [IW-1:0] ptr);
    if (ptr == IW'(MAX_OUTSTANDING - 1)) begin
      return IW'(0);
    end else begin
      return ptr + IW'(1);
    end
  endfunction

  // Issue/accept/response decode; credit counts queued plus still-wanted in-flight instructions
  always_comb begin
    w_used      = 32'(r_count) + 32'(r_outstanding) - 32'(r_discard);
    w_req_valid = reset & !bus.redirect_valid & !r_halted
                & (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                & (w_used < 32'(FQ_DEPTH));
    w_accept    = w_req_valid & bus.mem_req_ready;
    w_resp      = bus.mem_resp_valid;
    w_push      = w_resp & !bus.redirect_valid & (r_discard == OW'(0)) & !r_halted;
    w_pkt_valid = (r_count != CW'(0)) & !bus.redirect_valid;
    w_pop       = w_pkt_valid & bus.dp_ready;
`ifdef FETCH_HALT_STOP_EN
    w_wfi       = w_push & (bus.mem_resp_inst == WFI_INST);
`else
    w_wfi       = 1'b0;
`endif
  end

  // Next-state for counters and the halt flag
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    w_resp_left       = r_outstanding;
    w_discard_nxt     = r_discard;
    w_count_nxt       = r_count;
    w_halted_nxt      = r_halted;

    if (w_accept && !w_resp) begin
      w_outstanding_nxt = r_outstanding + OW'(1);
    end else if (!w_accept && w_resp) begin
      w_outstanding_nxt = r_outstanding - OW'(1);
    end else begin
      w_outstanding_nxt = r_outstanding;
    end

    if (w_resp) begin
      w_resp_left = r_outstanding - OW'(1);
    end else begin
      w_resp_left = r_outstanding;
    end

    // After a redirect or WFI, everything still in flight belongs to the dead path
    if (bus.redirect_valid) begin
      w_discard_nxt = w_resp_left;
    end else if (w_wfi) begin
      w_discard_nxt = w_outstanding_nxt;
    end else if (w_resp && (r_discard != OW'(0))) begin
      w_discard_nxt = r_discard - OW'(1);
    end else begin
      w_discard_nxt = r_discard;
    end

    if (bus.redirect_valid) begin
      w_count_nxt = CW'(0);
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end

    if (bus.redirect_valid) begin
      w_halted_nxt = 1'b0;
    end else if (w_wfi) begin
      w_halted_nxt = 1'b1;
    end else begin
      w_halted_nxt = r_halted;
    end
  end

  // Control state: PC, pointers, counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_head        <= PW'(0);
      r_tail        <= PW'(0);
      r_count       <= CW'(0);
      r_if_rd       <= IW'(0);
      r_if_wr       <= IW'(0);
      r_outstanding <= OW'(0);
      r_discard     <= OW'(0);
      r_halted      <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      r_count       <= w_count_nxt;
      r_halted      <= w_halted_nxt;

      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end else begin
        r_fetch_pc <= r_fetch_pc;
      end

      if (bus.redirect_valid) begin
        r_head <= PW'(0);
        r_tail <= PW'(0);
      end else begin
        r_head <= w_pop  ? (r_head + PW'(1)) : r_head;
        r_tail <= w_push ? (r_tail + PW'(1)) : r_tail;
      end

      // The in-flight PC FIFO tracks every response, discarded or not
      r_if_wr <= w_accept ? next_if_ptr(r_if_wr) : r_if_wr;
      r_if_rd <= w_resp   ? next_if_ptr(r_if_rd) : r_if_rd;
    end
  end

  // Data storage for the instruction queue and in-flight PCs
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_inst[r_tail] <= bus.mem_resp_inst;
      r_q_pc[r_tail]   <= r_if_pc[r_if_rd];
    end else begin
      r_q_inst[r_tail] <= r_q_inst[r_tail];
      r_q_pc[r_tail]   <= r_q_pc[r_tail];
    end
    if (w_accept) begin
      r_if_pc[r_if_wr] <= r_fetch_pc;
    end else begin
      r_if_pc[r_if_wr] <= r_if_pc[r_if_wr];
    end
  end

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign bus.if_packet     = {r_q_inst[r_head], r_q_pc[r_head], r_q_pc[r_head] + 32'd4, w_pkt_valid};
  assign bus.fq_count      = r_count;
`ifdef FETCH_HALT_STOP_EN
  assign bus.fetch_halted  = r_halted;
`else
  assign bus.fetch_halted  = 1'b0;
`endif

  fetch_queue_chk #(
    .FQ_DEPTH       (FQ_DEPTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CW             (CW),
    .OW             (OW)
  ) u_chk (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_count      (r_count),
    .i_resp       (w_resp),
    .i_outstanding(r_outstanding)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model, in-order Imem model, directed and random phases.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_queue_if #(.FQ_DEPTH(8)) bus();

  fetch_queue #(.FQ_DEPTH(8), .MAX_OUTSTANDING(4), .RESET_PC(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  ent_t        m_q[$];
  logic [31:0] mem_q[$];
  int          m_discard;
  bit          m_halted;
  bit          wfi_en;
  logic [31:0] wfi_addr;

  // DUT observations for the literal checks
  logic [31:0] seen_pc[$];
  int          dut_acc;
  logic [31:0] first_acc_addr;
  int          obs_count;
  bit          obs_req;
  bit          obs_pv;
  bit          obs_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    if (wfi_en && (addr == wfi_addr)) return 32'h1050_0073;
    return {addr[15:0], 16'h1234};
  endfunction

  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit dp, input bit rsp_ok);
    ent_t        e;
    logic [31:0] rp;
    bit          resp;
    bit          exp_req;
    bit          exp_pv;
    bit          acc;
    bit          wfi;
    @(posedge clock);
    #1;
    resp = rsp_ok && (mem_q.size() > 0);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.mem_req_ready  = rdy;
    bus.dp_ready       = dp;
    bus.mem_resp_valid = resp;
    bus.mem_resp_inst  = resp ? inst_of(mem_q[0]) : $urandom();
    @(negedge clock);
    exp_req = !redir && !m_halted && (mem_q.size() < 4) && ((m_q.size() + mem_q.size() - m_discard) < 8);
    exp_pv  = (m_q.size() > 0) && !redir;
    obs_count = 32'(bus.fq_count);
    obs_req   = bus.mem_req_valid;
    obs_pv    = bus.if_packet.valid;
    obs_halt  = bus.fetch_halted;
    chk("req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", bus.mem_req_addr, m_pc);
    chk("pkt_valid", 32'(bus.if_packet.valid), 32'(exp_pv));
    if (exp_pv) begin
      chk("pkt_inst", bus.if_packet.inst, m_q[0].inst);
      chk("pkt_pc", bus.if_packet.pc, m_q[0].pc);
      chk("pkt_npc", bus.if_packet.npc, m_q[0].pc + 32'd4);
    end
    chk("fq_count", 32'(bus.fq_count), 32'(m_q.size()));
    chk("halted", 32'(bus.fetch_halted), 32'(m_halted));
    if (bus.if_packet.valid && dp) seen_pc.push_back(bus.if_packet.pc);
    if (bus.mem_req_valid && rdy) begin
      if (dut_acc == 0) first_acc_addr = bus.mem_req_addr;
      dut_acc++;
    end
    // advance the model to the state after the coming edge
    acc = exp_req && rdy;
    wfi = 1'b0;
    rp  = 32'h0;
    if (resp) rp = mem_q.pop_front();
    if (redir) begin
      m_q.delete();
      m_pc      = rpc;
      m_halted  = 1'b0;
      m_discard = mem_q.size();
    end else begin
      if (exp_pv && dp) void'(m_q.pop_front());
      if (resp) begin
        if (m_discard > 0) begin
          m_discard--;
        end else begin
          e.inst = inst_of(rp);
          e.pc   = rp;
          m_q.push_back(e);
`ifdef FETCH_HALT_STOP_EN
          if (e.inst == 32'h1050_0073) wfi = 1'b1;
`endif
        end
      end
      if (acc) begin
        mem_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      if (wfi) begin
        m_halted  = 1'b1;
        m_discard = mem_q.size();
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_inst  = 32'h0;
    bus.dp_ready       = 1'b0;
    m_q.delete();
    mem_q.delete();
    seen_pc.delete();
    m_pc      = 32'h0;
    m_discard = 0;
    m_halted  = 1'b0;
    dut_acc   = 0;
    first_acc_addr = 32'hFFFF_FFFF;
    repeat (cycles) @(negedge clock);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_pkt_valid", 32'(bus.if_packet.valid), 32'd0);
    chk("rst_fq_count", 32'(bus.fq_count), 32'd0);
    chk("rst_halted", 32'(bus.fetch_halted), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int rdy_p;
    int rsp_p;
    int dp_p;
    logic [31:0] tmp;
    logic [31:0] rpc;
    wfi_en   = 1'b0;
    wfi_addr = 32'h8;

    // streaming with 1-cycle memory
    do_reset(3);
    for (int k = 0; k < 12; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("stream_n", 32'(seen_pc.size()), 32'd10);
    chk("stream_pc0", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h0);
    chk("stream_pc1", (seen_pc.size() > 1) ? seen_pc[1] : 32'hFFFF_FFFF, 32'h4);
    chk("stream_pc2", (seen_pc.size() > 2) ? seen_pc[2] : 32'hFFFF_FFFF, 32'h8);
    chk("stream_pc9", (seen_pc.size() > 9) ? seen_pc[9] : 32'hFFFF_FFFF, 32'h24);

    // fill with dispatch stalled
    do_reset(2);
    for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("full_count", 32'(bus.fq_count), 32'd8);
    chk("full_acc", 32'(dut_acc), 32'd8);
    chk("full_req_valid", 32'(bus.mem_req_valid), 32'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("full_first_pop", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h0);
    chk("full_resumed", 32'(dut_acc > 8), 32'd1);

    // redirect with three requests outstanding
    do_reset(2);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    seen_pc.delete();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("redir_count_next", 32'(obs_count), 32'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("redir_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h100);

    // redirect, response and dp_ready together
    do_reset(2);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    seen_pc.delete();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("combo_count", 32'(obs_count), 32'd0);
    chk("combo_pkt_valid", 32'(obs_pv), 32'd0);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("combo_first_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h200);

    // WFI at 0x8
    do_reset(2);
    wfi_en = 1'b1;
    for (int k = 0; k < 15; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
`ifdef FETCH_HALT_STOP_EN
    chk("wfi_n", 32'(seen_pc.size()), 32'd3);
    chk("wfi_last", (seen_pc.size() > 2) ? seen_pc[2] : 32'hFFFF_FFFF, 32'h8);
    chk("wfi_halted", 32'(obs_halt), 32'd1);
    chk("wfi_req_valid", 32'(obs_req), 32'd0);
`else
    chk("wfi_n", 32'(seen_pc.size()), 32'd13);
    chk("wfi_halted", 32'(obs_halt), 32'd0);
`endif
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    seen_pc.delete();
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("wfi_restart_pc", (seen_pc.size() > 0) ? seen_pc[0] : 32'hFFFF_FFFF, 32'h40);
    chk("wfi_cleared", 32'(obs_halt), 32'd0);
    wfi_en = 1'b0;

    // reset asserted mid-run with five queued
    do_reset(2);
    for (int k = 0; k < 40 && m_q.size() != 5; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    @(posedge clock);
    #2;
    chk("pre_reset_count", 32'(bus.fq_count), 32'd5);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.fq_count), 32'd0);
    chk("mid_rst_pkt_valid", 32'(bus.if_packet.valid), 32'd0);
    chk("mid_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    do_reset(2);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("post_rst_first_req", first_acc_addr, 32'h0);

    // randomized traffic, including PC wrap-around
    do_reset(2);
    for (int ep = 0; ep < 6; ep++) begin
      rdy_p = $urandom_range(20, 100);
      rsp_p = $urandom_range(20, 100);
      dp_p  = $urandom_range(10, 100);
      for (int c = 0; c < 500; c++) begin
        tmp = $urandom();
        rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : {tmp[31:2], 2'b00};
        step($urandom_range(0, 99) < 3, rpc,
             $urandom_range(0, 99) < rdy_p,
             $urandom_range(0, 99) < dp_p,
             $urandom_range(0, 99) < rsp_p);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
